// File: rtl/data_stat.sv
// data_stat: per-channel windowed statistics (mean/min/max) over a merged,
// channel-tagged sample stream. Channels 0..2 each keep an independent window
// of 2**LOG2_N samples; tag 3 samples are dropped and counted (saturating).
module data_stat #(
  parameter int DW     = 16,
  parameter int LOG2_N = 2,
  parameter int CW     = 8
) (
  input  logic          clkd,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  input  logic [1:0]    din_ch,
  input  logic          clr,
  output logic          stat_vld,
  output logic [1:0]    stat_ch,
  output logic [DW-1:0] stat_mean,
  output logic [DW-1:0] stat_min,
  output logic [DW-1:0] stat_max,
  output logic [CW-1:0] drop_cnt
);

  // Sum needs LOG2_N guard bits so N full-scale samples never overflow.
  localparam int SW = DW + LOG2_N;
  localparam int NW = LOG2_N + 1;
  localparam logic [NW-1:0] LAST_IDX = NW'((1 << LOG2_N) - 1);

  logic accept;
  logic drop_hit;

  assign accept   = din_vld && (din_ch != 2'd3) && !clr;
  assign drop_hit = din_vld && (din_ch == 2'd3) && !clr;

  // Per-channel "window state including the current sample" and completion flags.
  logic [2:0]    done;
  logic [SW-1:0] sum_new [3];
  logic [DW-1:0] min_new [3];
  logic [DW-1:0] max_new [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : ch_g
      logic [NW-1:0] cnt_reg;
      logic [SW-1:0] sum_reg;
      logic [DW-1:0] min_reg;
      logic [DW-1:0] max_reg;
      logic          hit;
      logic          first;

      assign hit      = accept && (din_ch == 2'(gi));
      // An empty window ignores whatever stale sum/min/max is left over.
      assign first    = (cnt_reg == '0);
      assign done[gi] = hit && (cnt_reg == LAST_IDX);

      assign sum_new[gi] = first ? SW'(din) : sum_reg + SW'(din);
      assign min_new[gi] = (first || (din < min_reg)) ? din : min_reg;
      assign max_new[gi] = (first || (din > max_reg)) ? din : max_reg;

      // Accumulate this channel's window; restart it on completion or clear.
      always_ff @(posedge clkd or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
          sum_reg <= '0;
          min_reg <= '0;
          max_reg <= '0;
        end else if (clr) begin
          cnt_reg <= '0;
        end else if (hit) begin
          cnt_reg <= done[gi] ? '0 : cnt_reg + NW'(1);
          sum_reg <= sum_new[gi];
          min_reg <= min_new[gi];
          max_reg <= max_new[gi];
        end
      end
    end
  endgenerate

  // At most one channel completes per cycle, so a one-hot select suffices.
  logic [SW-1:0] sel_sum;
  logic [DW-1:0] sel_min;
  logic [DW-1:0] sel_max;

  // Pick the stats of whichever channel (if any) is completing now.
  always_comb begin
    sel_sum = '0;
    sel_min = '0;
    sel_max = '0;
    for (int i = 0; i < 3; i++) begin
      if (done[i]) begin
        sel_sum = sum_new[i];
        sel_min = min_new[i];
        sel_max = max_new[i];
      end
    end
  end

  // Register completed-window results (held until next completion) and drop count.
  always_ff @(posedge clkd or posedge rst) begin
    if (rst) begin
      stat_vld  <= 1'b0;
      stat_ch   <= '0;
      stat_mean <= '0;
      stat_min  <= '0;
      stat_max  <= '0;
      drop_cnt  <= '0;
    end else begin
      stat_vld <= |done;
      if (|done) begin
        stat_ch   <= din_ch;
        stat_mean <= sel_sum[SW-1:LOG2_N];
        stat_min  <= sel_min;
        stat_max  <= sel_max;
      end
      if (drop_hit && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_data_stat.sv
// Testbench for data_stat: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based reference model of the window statistics.
module tb_data_stat;

  localparam int DW     = 16;
  localparam int LOG2_N = 2;
  localparam int CW     = 8;
  localparam int N      = 1 << LOG2_N;
  localparam int DROP_MAX = (1 << CW) - 1;

  logic          clkd;
  logic          rst;
  logic [DW-1:0] din;
  logic          din_vld;
  logic [1:0]    din_ch;
  logic          clr;
  logic          stat_vld;
  logic [1:0]    stat_ch;
  logic [DW-1:0] stat_mean;
  logic [DW-1:0] stat_min;
  logic [DW-1:0] stat_max;
  logic [CW-1:0] drop_cnt;

  data_stat #(.DW(DW), .LOG2_N(LOG2_N), .CW(CW)) dut (
    .clkd      (clkd),
    .rst       (rst),
    .din       (din),
    .din_vld   (din_vld),
    .din_ch    (din_ch),
    .clr       (clr),
    .stat_vld  (stat_vld),
    .stat_ch   (stat_ch),
    .stat_mean (stat_mean),
    .stat_min  (stat_min),
    .stat_max  (stat_max),
    .drop_cnt  (drop_cnt)
  );

  initial clkd = 1'b0;
  always #5 clkd = ~clkd;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  // Reference model: the samples of each open window, plus expected outputs.
  int unsigned win_q [3][$];
  logic          exp_vld;
  logic [1:0]    exp_ch;
  logic [DW-1:0] exp_mean;
  logic [DW-1:0] exp_min;
  logic [DW-1:0] exp_max;
  int            exp_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".stat_vld"},  32'(stat_vld),  32'(exp_vld));
    chk({tag, ".stat_ch"},   32'(stat_ch),   32'(exp_ch));
    chk({tag, ".stat_mean"}, 32'(stat_mean), 32'(exp_mean));
    chk({tag, ".stat_min"},  32'(stat_min),  32'(exp_min));
    chk({tag, ".stat_max"},  32'(stat_max),  32'(exp_max));
    chk({tag, ".drop_cnt"},  32'(drop_cnt),  32'(exp_drop));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) win_q[i].delete();
    exp_vld  = 1'b0;
    exp_ch   = '0;
    exp_mean = '0;
    exp_min  = '0;
    exp_max  = '0;
    exp_drop = 0;
  endtask

  task automatic model_step(input logic v, input logic [1:0] ch, input logic [DW-1:0] d,
                            input logic c);
    longint unsigned s;
    int unsigned mn, mx;
    exp_vld = 1'b0;
    if (c) begin
      for (int i = 0; i < 3; i++) win_q[i].delete();
    end else if (v) begin
      if (ch == 2'd3) begin
        if (exp_drop < DROP_MAX) exp_drop++;
      end else begin
        win_q[ch].push_back(int'(d));
        if (win_q[ch].size() == N) begin
          s  = 0;
          mn = 32'hFFFF_FFFF;
          mx = 0;
          foreach (win_q[ch][k]) begin
            s += win_q[ch][k];
            if (win_q[ch][k] < mn) mn = win_q[ch][k];
            if (win_q[ch][k] > mx) mx = win_q[ch][k];
          end
          exp_vld  = 1'b1;
          exp_ch   = ch;
          exp_mean = DW'(s / N);
          exp_min  = DW'(mn);
          exp_max  = DW'(mx);
          win_q[ch].delete();
          $display("window ch=%0d mean=%0d min=%0d max=%0d", ch, exp_mean, exp_min, exp_max);
        end
      end
    end
  endtask

  // One clock of stimulus, then compare every output against the model.
  task automatic step(input logic v, input logic [1:0] ch, input logic [DW-1:0] d,
                      input logic c, input string tag);
    @(negedge clkd);
    din_vld = v;
    din_ch  = ch;
    din     = d;
    clr     = c;
    model_step(v, ch, d, c);
    @(posedge clkd);
    #1;
    check_all(tag);
    if (stat_vld === 1'b1) pulses++;
  endtask

  // Reset asserted and released away from the clock edge.
  task automatic pulse_reset(input string tag);
    @(negedge clkd);
    din_vld = 1'b0;
    clr     = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all({tag, ".in_rst"});
    @(posedge clkd);
    #1;
    check_all({tag, ".in_rst_edge"});
    @(negedge clkd);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    din     = '0;
    din_vld = 1'b0;
    din_ch  = '0;
    clr     = 1'b0;
    rst     = 1'b1;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clkd);
    rst = 1'b0;
    step(1'b0, 2'd0, 16'd0, 1'b0, "idle");

    // T1: ch1 1,2,3,4
    step(1'b1, 2'd1, 16'd1, 1'b0, "t1");
    step(1'b1, 2'd1, 16'd2, 1'b0, "t1");
    step(1'b1, 2'd1, 16'd3, 1'b0, "t1");
    step(1'b1, 2'd1, 16'd4, 1'b0, "t1");
    chk("t1.vld",  32'(stat_vld), 32'd1);
    chk("t1.ch",   32'(stat_ch), 32'd1);
    chk("t1.mean", 32'(stat_mean), 32'd2);
    chk("t1.min",  32'(stat_min), 32'd1);
    chk("t1.max",  32'(stat_max), 32'd4);
    step(1'b0, 2'd1, 16'd77, 1'b0, "t1.hold");

    // T2: interleaved ch0 / ch2
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'd0, 16'(10 * (i + 1)), 1'b0, "t2");
      step(1'b1, 2'd2, (i == 3) ? 16'd9 : 16'd7, 1'b0, "t2");
    end
    step(1'b0, 2'd0, 16'd0, 1'b0, "t2.idle");
    chk("t2.pulses", 32'(pulses), 32'd2);
    chk("t2.ch2_mean", 32'(stat_mean), 32'd7);

    // T3: full scale then zeros
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 16'hFFFF, 1'b0, "t3a");
    chk("t3.mean_ffff", 32'(stat_mean), 32'hFFFF);
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 16'h0000, 1'b0, "t3b");
    chk("t3.max_zero", 32'(stat_max), 32'd0);

    // T4: clear discards partial window and its own sample
    pulses = 0;
    step(1'b1, 2'd1, 16'd5, 1'b0, "t4");
    step(1'b1, 2'd1, 16'd6, 1'b0, "t4");
    step(1'b1, 2'd1, 16'd7, 1'b0, "t4");
    step(1'b1, 2'd1, 16'd100, 1'b1, "t4.clr");
    for (int i = 0; i < 4; i++) step(1'b1, 2'd1, 16'd1, 1'b0, "t4");
    step(1'b0, 2'd1, 16'd0, 1'b0, "t4.idle");
    chk("t4.pulses", 32'(pulses), 32'd1);
    chk("t4.mean", 32'(stat_mean), 32'd1);

    // T5: drop counter saturation with ch2 traffic interleaved
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 2'd3, 16'($urandom), 1'b0, "t5.drop");
      if (i % 3 == 0) step(1'b1, 2'd2, 16'($urandom), 1'b0, "t5.ch2");
    end
    step(1'b1, 2'd3, 16'd1, 1'b1, "t5.clr_drop");
    chk("t5.drop_sat", 32'(drop_cnt), 32'd255);

    // T6: reset mid-window, then a clean window of 8s
    for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 16'd3, 1'b0, "t6.pre");
    pulse_reset("t6");
    pulses = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 16'd8, 1'b0, "t6");
    chk("t6.vld",  32'(stat_vld), 32'd1);
    chk("t6.mean", 32'(stat_mean), 32'd8);
    chk("t6.min",  32'(stat_min), 32'd8);
    chk("t6.max",  32'(stat_max), 32'd8);
    chk("t6.pulses", 32'(pulses), 32'd1);

    // Randomized mixed traffic
    for (int i = 0; i < 600; i++) begin
      logic          v;
      logic [1:0]    ch;
      logic [DW-1:0] d;
      logic          c;
      v  = ($urandom_range(0, 3) != 0);
      ch = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       d = 16'hFFFF;
        1:       d = 16'h0000;
        default: d = 16'($urandom);
      endcase
      c  = ($urandom_range(0, 40) == 0);
      step(v, ch, d, c, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
